systolic_array_feeder: RTL and testbench
========================================

Name: systolic_array_feeder

Overview:
- Downstream stage of the systolic array controller. Starts on `array_start` and walks the A and B operand buffers tile by tile.
- Feeds skewed operand vectors into the systolic array edges.
- Pulses `data_done` once every output tile has been fed and drained. That pulse also clears the controller's start and buffer-write state.

Parameters:
DATA_WIDTH_BYTES  1  bytes per matrix element
ARRAY_HEIGHT  4  systolic rows; elements per A buffer word
ARRAY_WIDTH  4  systolic columns; elements per B buffer word
BUFFER_ADDRESS_WIDTH  10  A/B buffer address width

Ports:
clk  in  1  clock
reset_n  in  1  asynchronous active-low reset
start_i  in  1  level start from controller `array_start`
m  in  16  rows of A
n  in  16  shared dimension
p  in  16  columns of B
a_avail  in  16  A buffer words written so far (controller global count)
b_avail  in  16  B buffer words written so far
a_rd_addr  out  BUFFER_ADDRESS_WIDTH  A buffer read address
a_rd_data  in  ARRAY_HEIGHT*DATA_WIDTH_BYTES*8  A word, 1-cycle read latency
b_rd_addr  out  BUFFER_ADDRESS_WIDTH  B buffer read address
b_rd_data  in  ARRAY_WIDTH*DATA_WIDTH_BYTES*8  B word, 1-cycle read latency
array_a_o  out  ARRAY_HEIGHT*DATA_WIDTH_BYTES*8  skewed row operands; lane r = row r
array_b_o  out  ARRAY_WIDTH*DATA_WIDTH_BYTES*8  skewed column operands; lane c = column c
array_valid_o  out  1  operand lanes advance this cycle
array_clear_o  out  1  one-cycle accumulator clear at tile start
tile_row_o  out  16  current tile row index
tile_col_o  out  16  current tile column index
data_done  out  1  one-cycle completion pulse

Behaviour:
- Reset values: all outputs 0; FSM = IDLE; skew registers 0.
- Start and operand latching:
  - In IDLE, a start_i high latches m, n and p.
  - TR = ceil(m/ARRAY_HEIGHT) and TC = ceil(p/ARRAY_WIDTH), computed with shift/add only, no multipliers.
  - start_i is ignored outside IDLE.
- FSM states:
  - IDLE -> FEED on start_i when m, n and p are all nonzero.
  - IDLE -> DONE on start_i when any of m, n, p is 0.
  - FEED -> DRAIN after issuing k = n-1 for the current tile.
  - DRAIN -> FEED for the next tile, after ARRAY_HEIGHT+ARRAY_WIDTH-1 valid drain cycles.
  - DRAIN -> DONE after the last tile.
  - DONE -> IDLE after 1 cycle; data_done = 1 only in DONE.
  - DONE to IDLE only; start_i must drop before a re-trigger (controller clears `array_start` on data_done).
- Tile order: column index inner, row index outer, i.e. (0,0), (0,1) … (0,TC-1), (1,0) …
- Read addressing in FEED:
  - Tile (i,j), step k: A linear index = i*n + k; B linear index = j*n + k.
  - Both indices are maintained by incrementing 16-bit counters.
  - Addresses are the low BUFFER_ADDRESS_WIDTH bits of the index; wrap-around is allowed.
- Stall:
  - A step issues only if A index < a_avail and B index < b_avail.
  - Otherwise addresses hold and the whole skew pipeline holds.
  - array_valid_o is 0 on stalled cycles.
  - Comparisons are unsigned 16-bit.
- Read latency: data returns 1 cycle after the address and is captured into lane 0 of each skew chain.
- Skew:
  - Row lane r is delayed r extra valid cycles; column lane c is delayed c extra valid cycles.
  - In DRAIN, zeros are shifted in.
- array_valid_o: high for every non-stalled FEED cycle (after the 1-cycle read latency) and every DRAIN cycle.
- array_clear_o: pulses in the cycle before the first valid operand of each tile.
- tile_row_o / tile_col_o: update coincident with array_clear_o.
- Simultaneous events:
  - If a_avail increments in the same cycle as the comparison, the registered (old) value is used.
  - start_i in the same cycle as DONE is ignored.
- Reset mid-operation: immediate return to IDLE; all outputs 0; skew chains cleared.

Optional Feature:
- FEEDER_ZERO_PAD_EN defined:
  - In the last row tile, lanes r with i*ARRAY_HEIGHT+r >= m output 0.
  - In the last column tile, lanes c with j*ARRAY_WIDTH+c >= p output 0.
- Undefined: buffer data passes unmodified; the downstream collector discards out-of-range results.

Test Plan:
- m=4, n=3, p=4, a_avail=b_avail=3 before start:
  - reads A addr 0,1,2 and B addr 0,1,2;
  - 3+7 valid cycles, then one tile, data_done pulses once, 11 cycles after the first read issues.
- m=8, n=2, p=8, all data present:
  - tile order (0,0),(0,1),(1,0),(1,1);
  - A addrs 0,1,0,1,2,3,2,3; B addrs 0,1,2,3,0,1,2,3;
  - 4 array_clear_o pulses.
- m=4, n=4, p=4 with a_avail held at 2 for 5 cycles, then set to 4:
  - a_rd_addr holds 2 and array_valid_o stays 0 for those 5 cycles;
  - skew output resumes without a lost or duplicated element.
- n=0 with start_i: data_done pulses in the cycle after start, with no reads and no valid.
- Reset asserted mid-FEED of m=8, n=8, p=8:
  - all outputs 0 immediately;
  - a new start_i with m=4, n=1, p=4 completes normally.
- With FEEDER_ZERO_PAD_EN defined, m=3, p=2, n=1 and nonzero buffer data: array_a_o lane 3 and array_b_o lanes 2-3 are always 0.

Source files
------------

// File: rtl/systolic_array_feeder.sv
// -----------------------------------------------------------------------------
// systolic_array_feeder
//
// Walks the A and B operand buffers tile by tile and feeds skewed operand
// vectors into the edges of an ARRAY_HEIGHT x ARRAY_WIDTH systolic array.
// Tiles are visited column-inner / row-outer. For tile (i, j) and step k the
// A buffer is read at i*n + k and the B buffer at j*n + k (low address bits,
// wrap-around allowed). A step issues only when both indices are below the
// controller's written-word counts; otherwise the whole pipeline holds.
// After the last step of a tile, ARRAY_HEIGHT+ARRAY_WIDTH-1 zero cycles drain
// the skew chains. data_done pulses once after the last tile has drained.
//
// ARRAY_HEIGHT and ARRAY_WIDTH must be powers of two: tile counts are derived
// with a round-up add and a right shift.
//
// Optional feature (compile-time macro FEEDER_ZERO_PAD_EN):
//   defined   - lanes whose matrix row (A) / column (B) lies beyond m (p) in the
//               last row/column tile are forced to zero.
//   undefined - buffer data passes unmodified.
//
// Ports:
//   clk, reset_n        clock, asynchronous active-low reset
//   start_i             level start from the controller (sampled in IDLE only)
//   m, n, p             matrix dimensions, latched on start
//   a_avail, b_avail    A/B buffer words written so far
//   a_rd_addr/a_rd_data A buffer read port, 1-cycle read latency
//   b_rd_addr/b_rd_data B buffer read port, 1-cycle read latency
//   array_a_o           skewed row operands, lane r = row r
//   array_b_o           skewed column operands, lane c = column c
//   array_valid_o       operand lanes advance this cycle
//   array_clear_o       accumulator clear, cycle before a tile's first operand
//   tile_row_o/_col_o   current tile indices, update with array_clear_o
//   data_done           one-cycle completion pulse
// -----------------------------------------------------------------------------
module systolic_array_feeder #(
    parameter int unsigned DATA_WIDTH_BYTES     = 1,
    parameter int unsigned ARRAY_HEIGHT         = 4,
    parameter int unsigned ARRAY_WIDTH          = 4,
    parameter int unsigned BUFFER_ADDRESS_WIDTH = 10
) (
    input  logic                                      clk,
    input  logic                                      reset_n,
    input  logic                                      start_i,
    input  logic [15:0]                               m,
    input  logic [15:0]                               n,
    input  logic [15:0]                               p,
    input  logic [15:0]                               a_avail,
    input  logic [15:0]                               b_avail,
    output logic [BUFFER_ADDRESS_WIDTH-1:0]           a_rd_addr,
    input  logic [ARRAY_HEIGHT*DATA_WIDTH_BYTES*8-1:0] a_rd_data,
    output logic [BUFFER_ADDRESS_WIDTH-1:0]           b_rd_addr,
    input  logic [ARRAY_WIDTH*DATA_WIDTH_BYTES*8-1:0]  b_rd_data,
    output logic [ARRAY_HEIGHT*DATA_WIDTH_BYTES*8-1:0] array_a_o,
    output logic [ARRAY_WIDTH*DATA_WIDTH_BYTES*8-1:0]  array_b_o,
    output logic                                      array_valid_o,
    output logic                                      array_clear_o,
    output logic [15:0]                               tile_row_o,
    output logic [15:0]                               tile_col_o,
    output logic                                      data_done
);

    localparam int unsigned ElemW  = DATA_WIDTH_BYTES * 8;
    localparam int unsigned HShift = $clog2(ARRAY_HEIGHT);
    localparam int unsigned WShift = $clog2(ARRAY_WIDTH);
    localparam logic [15:0] DrainLast = 16'(ARRAY_HEIGHT + ARRAY_WIDTH - 2);

    localparam logic [1:0] StIdle  = 2'd0;
    localparam logic [1:0] StFeed  = 2'd1;
    localparam logic [1:0] StDrain = 2'd2;
    localparam logic [1:0] StDone  = 2'd3;

    logic [1:0]  state_q, state_d;
    logic [15:0] k_q, k_d;
    logic [15:0] a_idx_q, a_idx_d;
    logic [15:0] b_idx_q, b_idx_d;
    logic [15:0] a_base_q, a_base_d;   // i*n, start of the current row tile in A
    logic [15:0] i_q, i_d;
    logic [15:0] j_q, j_d;
    logic [15:0] tr_q, tr_d;
    logic [15:0] tc_q, tc_d;
    logic [15:0] n_q, n_d;
    logic [15:0] drain_q, drain_d;
    logic        issued_q, issued_d;   // a read was issued last cycle, data on rd_data now
    logic [15:0] tile_row_q, tile_row_d;
    logic [15:0] tile_col_q, tile_col_d;
`ifdef FEEDER_ZERO_PAD_EN
    logic [15:0] m_q, m_d;
    logic [15:0] p_q, p_d;
`endif

    logic [16:0] m_round, p_round;
    logic [15:0] tr_calc, tc_calc;
    logic        dim_zero;
    logic        issue;
    logic        adv;
    logic        last_col, last_row;

    // Round-up division by a power-of-two array dimension.
    assign m_round  = {1'b0, m} + 17'(ARRAY_HEIGHT - 1);
    assign p_round  = {1'b0, p} + 17'(ARRAY_WIDTH - 1);
    assign tr_calc  = 16'(m_round >> HShift);
    assign tc_calc  = 16'(p_round >> WShift);
    assign dim_zero = (m == 16'd0) || (n == 16'd0) || (p == 16'd0);

    // avail inputs are the controller's registered counts, so the value seen
    // here is the one from before any same-cycle increment.
    assign issue = (state_q == StFeed) && (a_idx_q < a_avail) && (b_idx_q < b_avail);

    // Lanes advance while read data is arriving and on every drain cycle.
    assign adv = issued_q || (state_q == StDrain);

    assign last_col = (j_q == tc_q - 16'd1);
    assign last_row = (i_q == tr_q - 16'd1);

    always_comb begin
        state_d  = state_q;
        k_d      = k_q;
        a_idx_d  = a_idx_q;
        b_idx_d  = b_idx_q;
        a_base_d = a_base_q;
        i_d      = i_q;
        j_d      = j_q;
        tr_d     = tr_q;
        tc_d     = tc_q;
        n_d      = n_q;
        drain_d  = drain_q;
`ifdef FEEDER_ZERO_PAD_EN
        m_d      = m_q;
        p_d      = p_q;
`endif
        case (state_q)
            StIdle: begin
                if (start_i) begin
                    tr_d     = tr_calc;
                    tc_d     = tc_calc;
                    n_d      = n;
`ifdef FEEDER_ZERO_PAD_EN
                    m_d      = m;
                    p_d      = p;
`endif
                    i_d      = 16'd0;
                    j_d      = 16'd0;
                    k_d      = 16'd0;
                    a_idx_d  = 16'd0;
                    b_idx_d  = 16'd0;
                    a_base_d = 16'd0;
                    drain_d  = 16'd0;
                    state_d  = dim_zero ? StDone : StFeed;
                end
            end
            StFeed: begin
                if (issue) begin
                    a_idx_d = a_idx_q + 16'd1;
                    b_idx_d = b_idx_q + 16'd1;
                    if (k_q == n_q - 16'd1) begin
                        k_d     = 16'd0;
                        drain_d = 16'd0;
                        state_d = StDrain;
                    end else begin
                        k_d = k_q + 16'd1;
                    end
                end
            end
            StDrain: begin
                // The first DRAIN cycle still captures the tile's last read;
                // only the zero-shift cycles after it are counted.
                if (!issued_q) begin
                    if (drain_q == DrainLast) begin
                        drain_d = 16'd0;
                        if (last_row && last_col) begin
                            state_d = StDone;
                        end else begin
                            state_d = StFeed;
                            if (last_col) begin
                                // Next row tile: A continues at (i+1)*n, B restarts.
                                j_d      = 16'd0;
                                i_d      = i_q + 16'd1;
                                a_base_d = a_idx_q;
                                b_idx_d  = 16'd0;
                            end else begin
                                // Next column tile: B continues at (j+1)*n, A rewinds.
                                j_d     = j_q + 16'd1;
                                a_idx_d = a_base_q;
                            end
                        end
                    end else begin
                        drain_d = drain_q + 16'd1;
                    end
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    assign issued_d   = issue;
    assign tile_row_d = array_clear_o ? i_q : tile_row_q;
    assign tile_col_d = array_clear_o ? j_q : tile_col_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= StIdle;
            k_q        <= 16'd0;
            a_idx_q    <= 16'd0;
            b_idx_q    <= 16'd0;
            a_base_q   <= 16'd0;
            i_q        <= 16'd0;
            j_q        <= 16'd0;
            tr_q       <= 16'd0;
            tc_q       <= 16'd0;
            n_q        <= 16'd0;
            drain_q    <= 16'd0;
            issued_q   <= 1'b0;
            tile_row_q <= 16'd0;
            tile_col_q <= 16'd0;
`ifdef FEEDER_ZERO_PAD_EN
            m_q        <= 16'd0;
            p_q        <= 16'd0;
`endif
        end else begin
            state_q    <= state_d;
            k_q        <= k_d;
            a_idx_q    <= a_idx_d;
            b_idx_q    <= b_idx_d;
            a_base_q   <= a_base_d;
            i_q        <= i_d;
            j_q        <= j_d;
            tr_q       <= tr_d;
            tc_q       <= tc_d;
            n_q        <= n_d;
            drain_q    <= drain_d;
            issued_q   <= issued_d;
            tile_row_q <= tile_row_d;
            tile_col_q <= tile_col_d;
`ifdef FEEDER_ZERO_PAD_EN
            m_q        <= m_d;
            p_q        <= p_d;
`endif
        end
    end

    // Row lane r: r extra register stages, advanced only on valid cycles.
    for (genvar r = 0; r < ARRAY_HEIGHT; r++) begin : g_a_lane
        logic [ElemW-1:0] lane_in;
        logic [ElemW-1:0] sk_q [0:r];
`ifdef FEEDER_ZERO_PAD_EN
        logic pad;
        assign pad     = (({16'd0, i_q} << HShift) + 32'(r)) >= {16'd0, m_q};
        assign lane_in = (issued_q && !pad) ? a_rd_data[r*ElemW +: ElemW] : '0;
`else
        assign lane_in = issued_q ? a_rd_data[r*ElemW +: ElemW] : '0;
`endif
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                for (int d = 0; d <= r; d++) begin
                    sk_q[d] <= '0;
                end
            end else if (adv) begin
                sk_q[0] <= lane_in;
                for (int d = 1; d <= r; d++) begin
                    sk_q[d] <= sk_q[d-1];
                end
            end
        end
        assign array_a_o[r*ElemW +: ElemW] = sk_q[r];
    end

    // Column lane c: c extra register stages.
    for (genvar c = 0; c < ARRAY_WIDTH; c++) begin : g_b_lane
        logic [ElemW-1:0] lane_in;
        logic [ElemW-1:0] sk_q [0:c];
`ifdef FEEDER_ZERO_PAD_EN
        logic pad;
        assign pad     = (({16'd0, j_q} << WShift) + 32'(c)) >= {16'd0, p_q};
        assign lane_in = (issued_q && !pad) ? b_rd_data[c*ElemW +: ElemW] : '0;
`else
        assign lane_in = issued_q ? b_rd_data[c*ElemW +: ElemW] : '0;
`endif
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                for (int d = 0; d <= c; d++) begin
                    sk_q[d] <= '0;
                end
            end else if (adv) begin
                sk_q[0] <= lane_in;
                for (int d = 1; d <= c; d++) begin
                    sk_q[d] <= sk_q[d-1];
                end
            end
        end
        assign array_b_o[c*ElemW +: ElemW] = sk_q[c];
    end

    assign a_rd_addr     = a_idx_q[BUFFER_ADDRESS_WIDTH-1:0];
    assign b_rd_addr     = b_idx_q[BUFFER_ADDRESS_WIDTH-1:0];
    assign array_valid_o = adv;
    // First issue of a tile: its operand reaches lane 0 on the next cycle.
    assign array_clear_o = issue && (k_q == 16'd0);
    assign tile_row_o    = tile_row_d;
    assign tile_col_o    = tile_col_d;
    assign data_done     = (state_q == StDone);

endmodule

// File: tb/tb_systolic_array_feeder.sv
module tb_systolic_array_feeder;
    localparam int H     = 4;
    localparam int W     = 4;
    localparam int EW    = 8;
    localparam int AW    = H * EW;
    localparam int BW    = W * EW;
    localparam int ABW   = 10;
    localparam int DEPTH = 1 << ABW;
`ifdef FEEDER_ZERO_PAD_EN
    localparam bit PAD = 1'b1;
`else
    localparam bit PAD = 1'b0;
`endif

    logic           clk;
    logic           reset_n;
    logic           start_i;
    logic [15:0]    m, n, p, a_avail, b_avail;
    logic [ABW-1:0] a_rd_addr, b_rd_addr;
    logic [AW-1:0]  a_rd_data, array_a_o;
    logic [BW-1:0]  b_rd_data, array_b_o;
    logic           array_valid_o, array_clear_o, data_done;
    logic [15:0]    tile_row_o, tile_col_o;

    systolic_array_feeder #(
        .DATA_WIDTH_BYTES    (1),
        .ARRAY_HEIGHT        (H),
        .ARRAY_WIDTH         (W),
        .BUFFER_ADDRESS_WIDTH(ABW)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .start_i      (start_i),
        .m            (m),
        .n            (n),
        .p            (p),
        .a_avail      (a_avail),
        .b_avail      (b_avail),
        .a_rd_addr    (a_rd_addr),
        .a_rd_data    (a_rd_data),
        .b_rd_addr    (b_rd_addr),
        .b_rd_data    (b_rd_data),
        .array_a_o    (array_a_o),
        .array_b_o    (array_b_o),
        .array_valid_o(array_valid_o),
        .array_clear_o(array_clear_o),
        .tile_row_o   (tile_row_o),
        .tile_col_o   (tile_col_o),
        .data_done    (data_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Operand buffers, 1-cycle read latency.
    logic [AW-1:0] amem [DEPTH];
    logic [BW-1:0] bmem [DEPTH];
    always @(posedge clk) begin
        a_rd_data <= amem[a_rd_addr];
        b_rd_data <= bmem[b_rd_addr];
    end

    int n_cmp = 0;
    int n_err = 0;

    logic [AW-1:0] aq [$];
    logic [BW-1:0] bq [$];
    logic [31:0]   tq [$];
    bit            pad_chk = 1'b0;

    function automatic void check(string name, logic [63:0] got, logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endfunction

    // Reference: after the s-th advance of tile (i,j), row lane r holds
    // element k = s - r of matrix row i*H+r, i.e. A buffer word i*n+k.
    function automatic logic [AW-1:0] exp_a(int i, int s, int mm, int nn);
        logic [AW-1:0] v;
        logic [AW-1:0] w;
        int k;
        v = '0;
        for (int r = 0; r < H; r++) begin
            k = s - r;
            if (k >= 0 && k < nn && !(PAD && (i * H + r >= mm))) begin
                w = amem[(i * nn + k) % DEPTH];
                v[r*EW +: EW] = w[r*EW +: EW];
            end
        end
        return v;
    endfunction

    function automatic logic [BW-1:0] exp_b(int j, int s, int pp, int nn);
        logic [BW-1:0] v;
        logic [BW-1:0] w;
        int k;
        v = '0;
        for (int c = 0; c < W; c++) begin
            k = s - c;
            if (k >= 0 && k < nn && !(PAD && (j * W + c >= pp))) begin
                w = bmem[(j * nn + k) % DEPTH];
                v[c*EW +: EW] = w[c*EW +: EW];
            end
        end
        return v;
    endfunction

    function automatic int tiles(int mm, int nn, int pp);
        if (mm == 0 || nn == 0 || pp == 0) return 0;
        return ((mm + H - 1) / H) * ((pp + W - 1) / W);
    endfunction

    // Monitor: one snapshot per advance, compared on the following cycle.
    bit prev_v = 1'b0;
    always @(negedge clk) begin
        logic [AW-1:0] ea;
        logic [BW-1:0] eb;
        logic [31:0]   et;
        if (!reset_n) begin
            prev_v = 1'b0;
        end else begin
            if (prev_v) begin
                if (aq.size() == 0 || bq.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL sb_underflow: got advance with empty queue at %0t", $time);
                end else begin
                    ea = aq.pop_front();
                    eb = bq.pop_front();
                    check("skew_a", 64'(array_a_o), 64'(ea));
                    check("skew_b", 64'(array_b_o), 64'(eb));
                end
            end
            if (array_clear_o) begin
                if (tq.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL tile_underflow: got clear with empty queue at %0t", $time);
                end else begin
                    et = tq.pop_front();
                    check("tile_pos", 64'({tile_row_o, tile_col_o}), 64'(et));
                end
            end
            if (pad_chk) begin
                check("pad_a_lane3", 64'(array_a_o[AW-1 -: EW]), 64'd0);
                check("pad_b_lanes23", 64'(array_b_o[BW-1 -: 2*EW]), 64'd0);
            end
            prev_v = array_valid_o;
        end
    end

    task automatic prepare(input int mm, input int nn, input int pp,
                           input logic [15:0] a0, input logic [15:0] b0);
        int tr;
        int tc;
        for (int x = 0; x < DEPTH; x++) begin
            amem[x] = AW'($urandom);
            bmem[x] = BW'($urandom);
        end
        m = 16'(mm);
        n = 16'(nn);
        p = 16'(pp);
        a_avail = a0;
        b_avail = b0;
        if (tiles(mm, nn, pp) != 0) begin
            tr = (mm + H - 1) / H;
            tc = (pp + W - 1) / W;
            for (int i = 0; i < tr; i++) begin
                for (int j = 0; j < tc; j++) begin
                    tq.push_back({16'(i), 16'(j)});
                    for (int s = 0; s < nn + H + W - 1; s++) begin
                        aq.push_back(exp_a(i, s, mm, nn));
                        bq.push_back(exp_b(j, s, pp, nn));
                    end
                end
            end
        end
    endtask

    // Entered and left at posedge+1; start_i drops once data_done is seen.
    task automatic run_to_done(input bit ramp, output int vcnt, output int fv,
                               output int dn, output int dcnt);
        int c;
        bit got;
        vcnt = 0;
        fv = -1;
        dn = -1;
        dcnt = 0;
        got = 1'b0;
        c = 0;
        start_i = 1'b1;
        while (!got && c < 4000) begin
            @(negedge clk);
            if (array_valid_o) begin
                vcnt++;
                if (fv < 0) fv = c;
            end
            if (data_done) begin
                dcnt++;
                dn = c;
                got = 1'b1;
            end
            @(posedge clk);
            #1;
            if (got) start_i = 1'b0;
            if (ramp) begin
                if ($urandom_range(0, 2) == 0 && a_avail != 16'hFFFF) a_avail = a_avail + 16'd1;
                if ($urandom_range(0, 2) == 0 && b_avail != 16'hFFFF) b_avail = b_avail + 16'd1;
            end
            c++;
        end
        if (!got) begin
            n_cmp++;
            n_err++;
            $display("FAIL done_timeout: got no data_done within %0d cycles", c);
            start_i = 1'b0;
        end
        repeat (3) begin
            @(negedge clk);
            if (data_done) dcnt++;
            if (array_valid_o) vcnt++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic post_check(input int mm, input int nn, input int pp,
                              input int vcnt, input int dcnt);
        int ev;
        ev = tiles(mm, nn, pp) * (nn + H + W - 1);
        check("valid_count", 64'(vcnt), 64'(ev));
        check("done_pulses", 64'(dcnt), 64'd1);
        check("sb_drained", 64'(aq.size() + bq.size() + tq.size()), 64'd0);
    endtask

    int vcnt, fv, dn, dcnt, v0, mm, nn, pp;
    bit found;

    initial begin
        reset_n = 1'b0;
        start_i = 1'b0;
        m = '0;
        n = '0;
        p = '0;
        a_avail = '0;
        b_avail = '0;
        for (int x = 0; x < DEPTH; x++) begin
            amem[x] = '0;
            bmem[x] = '0;
        end
        #1;
        check("reset_outputs", 64'({a_rd_addr, b_rd_addr, array_valid_o, array_clear_o,
                                    data_done, tile_row_o, tile_col_o}), 64'd0);
        check("reset_lanes", 64'({array_a_o, array_b_o}), 64'd0);
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        // Single tile, data pre-written.
        prepare(4, 3, 4, 16'd3, 16'd3);
        run_to_done(1'b0, vcnt, fv, dn, dcnt);
        post_check(4, 3, 4, vcnt, dcnt);
        check("t1_done_latency", 64'(dn - fv), 64'd10);

        // Four tiles, everything available.
        prepare(8, 2, 8, 16'hFFFF, 16'hFFFF);
        run_to_done(1'b0, vcnt, fv, dn, dcnt);
        post_check(8, 2, 8, vcnt, dcnt);

        // A stalls at index 2 until a_avail is raised.
        prepare(4, 4, 4, 16'd2, 16'hFFFF);
        start_i = 1'b1;
        v0 = 0;
        found = 1'b0;
        for (int c = 0; c < 20 && !found; c++) begin
            @(negedge clk);
            if (array_valid_o) v0++;
            if (a_rd_addr == ABW'(2)) found = 1'b1;
        end
        check("stall_reached", 64'(found), 64'd1);
        repeat (5) begin
            @(negedge clk);
            check("stall_addr", 64'(a_rd_addr), 64'd2);
            check("stall_valid", 64'(array_valid_o), 64'd0);
        end
        @(posedge clk);
        #1;
        a_avail = 16'd4;
        run_to_done(1'b0, vcnt, fv, dn, dcnt);
        post_check(4, 4, 4, vcnt + v0, dcnt);

        // Zero shared dimension: immediate done, no reads.
        prepare(4, 0, 4, 16'hFFFF, 16'hFFFF);
        run_to_done(1'b0, vcnt, fv, dn, dcnt);
        post_check(4, 0, 4, vcnt, dcnt);
        check("n0_done_cycle", 64'(dn), 64'd1);

        // Reset in the middle of FEED, then a fresh job.
        prepare(8, 8, 8, 16'hFFFF, 16'hFFFF);
        start_i = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        reset_n = 1'b0;
        #1;
        check("midrst_addr", 64'({a_rd_addr, b_rd_addr}), 64'd0);
        check("midrst_lanes", 64'({array_a_o, array_b_o}), 64'd0);
        check("midrst_ctrl", 64'({array_valid_o, array_clear_o, data_done,
                                  tile_row_o, tile_col_o}), 64'd0);
        start_i = 1'b0;
        aq.delete();
        bq.delete();
        tq.delete();
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        prepare(4, 1, 4, 16'hFFFF, 16'hFFFF);
        run_to_done(1'b0, vcnt, fv, dn, dcnt);
        post_check(4, 1, 4, vcnt, dcnt);

`ifdef FEEDER_ZERO_PAD_EN
        prepare(3, 1, 2, 16'hFFFF, 16'hFFFF);
        pad_chk = 1'b1;
        run_to_done(1'b0, vcnt, fv, dn, dcnt);
        pad_chk = 1'b0;
        post_check(3, 1, 2, vcnt, dcnt);
`endif

        // Degenerate m = 0.
        prepare(0, 3, 5, 16'hFFFF, 16'hFFFF);
        run_to_done(1'b0, vcnt, fv, dn, dcnt);
        post_check(0, 3, 5, vcnt, dcnt);

        // Random shapes with data trickling in.
        for (int t = 0; t < 10; t++) begin
            mm = $urandom_range(1, 9);
            nn = $urandom_range(1, 5);
            pp = $urandom_range(1, 9);
            prepare(mm, nn, pp, 16'($urandom_range(0, 2)), 16'($urandom_range(0, 2)));
            run_to_done(1'b1, vcnt, fv, dn, dcnt);
            post_check(mm, nn, pp, vcnt, dcnt);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
